// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte-push and serial-line bundle for the UART transmitter.
//
// Signals:
//   tx_data  [7:0]  byte offered for transmission (producer -> transmitter)
//   tx_valid        tx_data holds a byte to queue   (producer -> transmitter)
//   tx_ready        transmit FIFO has a free entry  (transmitter -> producer)
//   tx              serial line, idle high          (transmitter -> line)
//   tx_busy         frame in progress or bytes queued
//   tx_done         one-cycle pulse at the end of each stop bit
//
// Modports:
//   master -- the byte producer side
//   slave  -- the transmitter side
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a small transmit FIFO.
//
// Bytes pushed through the bus interface (tx_valid && tx_ready) are queued in
// a FIFO_DEPTH-entry FIFO and sent LSB first as start(0), 8 data bits,
// stop(1). Every bit lasts 16 s_ticks; one s_tick occurs every BAUD_DIV+1
// clocks from a free-running divider. Consecutive queued bytes go out with no
// idle time between the stop bit and the next start bit.
//
// Parameters:
//   BAUD_DIV    terminal value of the tick divider (s_tick every BAUD_DIV+1 clocks)
//   FIFO_DEPTH  transmit FIFO entries, power of two, at least 2
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any frame and empties the FIFO
//   bus  uart_tx_if.slave: tx_data/tx_valid in, tx_ready/tx/tx_busy/tx_done out
module uart_tx #(
  parameter int BAUD_DIV   = 650,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int TICK_W = (BAUD_DIV < 1) ? 1 : $clog2(BAUD_DIV + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Tick divider
  logic [TICK_W-1:0] r_tickCnt;
  logic              w_sTick;

  // Transmit FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_ready;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;

  // Frame FSM
  state_t     r_state;
  state_t     w_stateNext;
  logic [3:0] r_sCount;
  logic [3:0] w_sCountNext;
  logic [2:0] r_nCount;
  logic [2:0] w_nCountNext;
  logic [7:0] r_shift;
  logic [7:0] w_shiftNext;
  logic       r_tx;
  logic       w_txNext;
  logic       r_done;
  logic       w_doneNext;

  // ---------------------------------------------------------------------------
  // Free-running tick divider: counts 0..BAUD_DIV and pulses on the wrap.
  // ---------------------------------------------------------------------------
  assign w_sTick = (r_tickCnt == TICK_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tickCnt <= '0;
    end else if (w_sTick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FIFO. Occupancy is registered, so a byte pushed into an empty
  // FIFO becomes visible to the FSM one clock later. The storage array needs
  // no reset: only entries between the pointers are ever read.
  // ---------------------------------------------------------------------------
  assign w_ready = (r_count < FIFO_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.tx_valid && w_ready;
  assign w_head  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register. The line register only loads on s_tick edges so that
  // every bit boundary lines up with the tick grid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sCount <= '0;
      r_nCount <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_sCount <= w_sCountNext;
      r_nCount <= w_nCountNext;
      r_shift  <= w_shiftNext;
      r_done   <= w_doneNext;
      if (w_sTick) begin
        r_tx <= w_txNext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic. Everything advances only on s_tick; the FIFO is
  // popped when heading into START, from IDLE or directly from STOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stateNext  = r_state;
    w_sCountNext = r_sCount;
    w_nCountNext = r_nCount;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;
    w_doneNext   = 1'b0;
    if (w_sTick) begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shiftNext  = w_head;
            w_sCountNext = '0;
            w_stateNext  = START;
          end
        end
        START: begin
          if (r_sCount == 4'd15) begin
            w_sCountNext = '0;
            w_nCountNext = '0;
            w_stateNext  = DATA;
          end else begin
            w_sCountNext = r_sCount + 1'b1;
          end
        end
        DATA: begin
          if (r_sCount == 4'd15) begin
            w_sCountNext = '0;
            w_shiftNext  = {1'b0, r_shift[7:1]};
            if (r_nCount == 3'd7) begin
              w_stateNext = STOP;
            end else begin
              w_nCountNext = r_nCount + 1'b1;
            end
          end else begin
            w_sCountNext = r_sCount + 1'b1;
          end
        end
        STOP: begin
          if (r_sCount == 4'd15) begin
            w_doneNext   = 1'b1;
            w_sCountNext = '0;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_shiftNext = w_head;
              w_stateNext = START;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            w_sCountNext = r_sCount + 1'b1;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM output logic. The line level is derived from the state being entered,
  // so the registered tx already shows the new bit right after the tick edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.tx_done  = r_done;
  assign bus.tx_ready = w_ready;
  assign bus.tx_busy  = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed testbench for uart_tx with BAUD_DIV=3, FIFO_DEPTH=4.
// A bit lasts 64 clocks and a frame 640 clocks. A negedge monitor logs the
// DUT outputs every clock; scenario tasks drive the bus and compare the log
// against hand-derived frame timing and contents.
module tb_uart_tx;

  localparam int BAUD_DIV   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = 640;
  localparam int LOG_LEN    = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_if bus();

  uart_tx #(
    .BAUD_DIV  (BAUD_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  logic logTx    [LOG_LEN];
  logic logDone  [LOG_LEN];
  logic logBusy  [LOG_LEN];
  logic logReady [LOG_LEN];
  int   cyc = 0;

  // Output log, one entry per clock, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc < LOG_LEN) begin
      logTx[cyc]    <= bus.tx;
      logDone[cyc]  <= bus.tx_done;
      logBusy[cyc]  <= bus.tx_busy;
      logReady[cyc] <= bus.tx_ready;
      cyc           <= cyc + 1;
    end
  end

  // Advance n clocks; afterwards the newest log entry is cyc-1.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick_n(1);
    bus.tx_valid = 1'b0;
  endtask

  // Line level of frame bit k: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic int find_fall(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (logTx[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  task automatic test_reset;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    vecCount++;
    if (bus.tx !== 1'b1) begin
      missCount++; $display("[TB] FAIL reset_tx: got %b expected 1", bus.tx);
    end
    vecCount++;
    if (bus.tx_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.tx_ready);
    end
    vecCount++;
    if (bus.tx_busy !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.tx_busy);
    end
    vecCount++;
    if (bus.tx_done !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_done: got %b expected 0", bus.tx_done);
    end
    tick_n(3);
    rst = 1'b0;
    tick_n(2);
    vecCount++;
    if (bus.tx !== 1'b1) begin
      missCount++; $display("[TB] FAIL idle_tx: got %b expected 1", bus.tx);
    end
  endtask

  task automatic test_single_frame;
    int from, s, nd;
    from = cyc;
    push_byte(8'h55);
    tick_n(FRAME_CLKS + 60);
    s = find_fall(from, cyc);
    vecCount++;
    if (s < 0 || s - from > 8) begin
      missCount++; $display("[TB] FAIL single_start: got offset %0d expected 0..8", s - from);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      vecCount++;
      if (logTx[s + 32 + BIT_CLKS*k] !== exp_bit(8'h55, k)) begin
        missCount++;
        $display("[TB] FAIL single_bit%0d: got %b expected %b", k, logTx[s + 32 + BIT_CLKS*k], exp_bit(8'h55, k));
      end
    end
    nd = 0;
    for (int i = s; i < s + FRAME_CLKS + 40; i++) if (logDone[i] === 1'b1) nd++;
    vecCount++;
    if (nd != 1) begin
      missCount++; $display("[TB] FAIL single_done_count: got %0d expected 1", nd);
    end
    vecCount++;
    if (logDone[s + FRAME_CLKS] !== 1'b1) begin
      missCount++; $display("[TB] FAIL single_done_time: got %b expected 1 at +640", logDone[s + FRAME_CLKS]);
    end
    vecCount++;
    if (logBusy[s + FRAME_CLKS - 1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL single_busy_stop: got %b expected 1", logBusy[s + FRAME_CLKS - 1]);
    end
    vecCount++;
    if (logBusy[s + FRAME_CLKS] !== 1'b0) begin
      missCount++; $display("[TB] FAIL single_busy_after: got %b expected 0", logBusy[s + FRAME_CLKS]);
    end
  endtask

  task automatic test_back_to_back;
    int from, s, k, guard, np, nd;
    int pushAt [6];
    logic willPush;
    logic [7:0] b;
    from  = cyc;
    k     = 0;
    guard = 0;
    bus.tx_data  = 8'h01;
    bus.tx_valid = 1'b1;
    while (k < 6 && guard < 2000) begin
      willPush = (logReady[cyc-1] === 1'b1);
      tick_n(1);
      guard++;
      if (willPush) begin
        pushAt[k] = cyc - 1;
        k++;
        if (k < 6) bus.tx_data = 8'(k + 1);
        else bus.tx_valid = 1'b0;
      end
    end
    bus.tx_valid = 1'b0;
    vecCount++;
    if (k != 6) begin
      missCount++; $display("[TB] FAIL b2b_pushes: got %0d expected 6", k);
      return;
    end
    tick_n(6*FRAME_CLKS);
    s = find_fall(from, cyc);
    vecCount++;
    if (s < 0) begin
      missCount++; $display("[TB] FAIL b2b_start: got none expected a start bit");
      return;
    end
    np = 0;
    for (int i = 0; i < 6; i++) if (pushAt[i] <= s + 100) np++;
    vecCount++;
    if (np != 5) begin
      missCount++; $display("[TB] FAIL b2b_accepted: got %0d expected 5", np);
    end
    vecCount++;
    if (logReady[s + 100] !== 1'b0) begin
      missCount++; $display("[TB] FAIL b2b_ready_full: got %b expected 0", logReady[s + 100]);
    end
    vecCount++;
    if (pushAt[5] != s + FRAME_CLKS + 1) begin
      missCount++; $display("[TB] FAIL b2b_sixth_push: got %0d expected %0d", pushAt[5] - s, FRAME_CLKS + 1);
    end
    for (int j = 0; j < 6; j++) begin
      b = 8'(j + 1);
      for (int kk = 0; kk < 10; kk++) begin
        vecCount++;
        if (logTx[s + FRAME_CLKS*j + 32 + BIT_CLKS*kk] !== exp_bit(b, kk)) begin
          missCount++;
          $display("[TB] FAIL b2b_frame%0d_bit%0d: got %b expected %b", j, kk,
                   logTx[s + FRAME_CLKS*j + 32 + BIT_CLKS*kk], exp_bit(b, kk));
        end
      end
    end
    nd = 0;
    for (int i = s; i < s + 6*FRAME_CLKS + 20; i++) if (logDone[i] === 1'b1) nd++;
    vecCount++;
    if (nd != 6) begin
      missCount++; $display("[TB] FAIL b2b_done_count: got %0d expected 6", nd);
    end
    vecCount++;
    if (logBusy[s + 6*FRAME_CLKS] !== 1'b0) begin
      missCount++; $display("[TB] FAIL b2b_busy_after: got %b expected 0", logBusy[s + 6*FRAME_CLKS]);
    end
  endtask

  task automatic test_reset_midframe;
    int from, s, from2, nz, nd, nb;
    from = cyc;
    push_byte(8'h0F);
    push_byte(8'hAA);
    push_byte(8'hBB);
    tick_n(20);
    s = find_fall(from, cyc);
    vecCount++;
    if (s < 0) begin
      missCount++; $display("[TB] FAIL rstmid_start: got none expected a start bit");
      return;
    end
    // Middle of data bit 3 (frame bit 4).
    tick_n(s + 4*BIT_CLKS + 32 - (cyc - 1));
    vecCount++;
    if (logTx[cyc-1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL rstmid_bit3: got %b expected 1", logTx[cyc-1]);
    end
    vecCount++;
    if (logBusy[cyc-1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", logBusy[cyc-1]);
    end
    #2 rst = 1'b1;
    #1;
    vecCount++;
    if (bus.tx !== 1'b1) begin
      missCount++; $display("[TB] FAIL rstmid_tx: got %b expected 1", bus.tx);
    end
    vecCount++;
    if (bus.tx_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL rstmid_ready: got %b expected 1", bus.tx_ready);
    end
    vecCount++;
    if (bus.tx_busy !== 1'b0) begin
      missCount++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.tx_busy);
    end
    vecCount++;
    if (bus.tx_done !== 1'b0) begin
      missCount++; $display("[TB] FAIL rstmid_done: got %b expected 0", bus.tx_done);
    end
    tick_n(4);
    rst = 1'b0;
    from2 = cyc;
    tick_n(1500);
    nz = 0; nd = 0; nb = 0;
    for (int i = from2; i < cyc; i++) begin
      if (logTx[i] !== 1'b1) nz++;
      if (logDone[i] !== 1'b0) nd++;
      if (logBusy[i] !== 1'b0) nb++;
    end
    for (int i = s; i < from2; i++) if (logDone[i] === 1'b1) nd++;
    vecCount++;
    if (nz != 0) begin
      missCount++; $display("[TB] FAIL rstmid_line_idle: got %0d non-idle clocks expected 0", nz);
    end
    vecCount++;
    if (nd != 0) begin
      missCount++; $display("[TB] FAIL rstmid_no_done: got %0d done clocks expected 0", nd);
    end
    vecCount++;
    if (nb != 0) begin
      missCount++; $display("[TB] FAIL rstmid_no_busy: got %0d busy clocks expected 0", nb);
    end
  endtask

  task automatic test_data_change;
    int from, s;
    from = cyc;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    tick_n(1);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b0;
    tick_n(1);
    bus.tx_data  = 8'h00;
    tick_n(FRAME_CLKS + 60);
    s = find_fall(from, cyc);
    vecCount++;
    if (s < 0) begin
      missCount++; $display("[TB] FAIL hold_start: got none expected a start bit");
      return;
    end
    for (int k = 0; k < 10; k++) begin
      vecCount++;
      if (logTx[s + 32 + BIT_CLKS*k] !== exp_bit(8'h3C, k)) begin
        missCount++;
        $display("[TB] FAIL hold_bit%0d: got %b expected %b", k, logTx[s + 32 + BIT_CLKS*k], exp_bit(8'h3C, k));
      end
    end
  endtask

  task automatic test_push_pop_same_clock;
    int s, nd;
    logic [7:0] bytes [5];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55;
    s = -1;
    push_byte(bytes[0]);
    for (int g = 0; g < 20 && s < 0; g++) begin
      tick_n(1);
      if (logTx[cyc-1] === 1'b0) s = cyc - 1;
    end
    vecCount++;
    if (s < 0) begin
      missCount++; $display("[TB] FAIL pp_start: got none expected a start bit");
      return;
    end
    push_byte(bytes[1]);
    push_byte(bytes[2]);
    push_byte(bytes[3]);
    // Present the fifth byte so it is pushed on the clock that pops byte 2.
    tick_n(s + FRAME_CLKS - 1 - (cyc - 1));
    vecCount++;
    if (logReady[cyc-1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL pp_ready_before: got %b expected 1", logReady[cyc-1]);
    end
    bus.tx_data  = bytes[4];
    bus.tx_valid = 1'b1;
    tick_n(1);
    bus.tx_valid = 1'b0;
    vecCount++;
    if (logDone[cyc-1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL pp_pop_edge: got %b expected 1", logDone[cyc-1]);
    end
    vecCount++;
    if (logReady[cyc-1] !== 1'b1) begin
      missCount++; $display("[TB] FAIL pp_ready_after: got %b expected 1", logReady[cyc-1]);
    end
    tick_n(5*FRAME_CLKS);
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 10; k++) begin
        vecCount++;
        if (logTx[s + FRAME_CLKS*j + 32 + BIT_CLKS*k] !== exp_bit(bytes[j], k)) begin
          missCount++;
          $display("[TB] FAIL pp_frame%0d_bit%0d: got %b expected %b", j, k,
                   logTx[s + FRAME_CLKS*j + 32 + BIT_CLKS*k], exp_bit(bytes[j], k));
        end
      end
    end
    nd = 0;
    for (int i = s; i < s + 5*FRAME_CLKS + 20; i++) if (logDone[i] === 1'b1) nd++;
    vecCount++;
    if (nd != 5) begin
      missCount++; $display("[TB] FAIL pp_done_count: got %0d expected 5", nd);
    end
  endtask

  initial begin
    $display("[TB] uart_tx directed test, BAUD_DIV=%0d FIFO_DEPTH=%0d", BAUD_DIV, FIFO_DEPTH);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_midframe();
    test_data_change();
    test_push_pop_same_clock();
    vecCount++;
    if (cyc >= LOG_LEN) begin
      missCount++; $display("[TB] FAIL log_length: got %0d expected below %0d", cyc, LOG_LEN);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
